// File: rtl/img_pkg.sv
// Shared definitions for the image pipeline: FSM state codes, derived-width helpers
// and pixel slicing shared with the threshold/filter blocks.
package img_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_HSYNC  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int beat_w(input int pix_per_clk, input int chan_cnt, input int chan_w);
    return pix_per_clk * chan_cnt * chan_w;
  endfunction

  function automatic int addr_w(input int width, input int height, input int pix_per_clk);
    return $clog2(width * height / pix_per_clk);
  endfunction

  // LSB of channel c of pixel k inside a beat; pixel 0 is leftmost, channel 0 is red.
  function automatic int pix_lsb(input int k, input int c, input int chan_cnt, input int chan_w);
    return (k * chan_cnt + c) * chan_w;
  endfunction

endpackage

// File: rtl/img_stream_src_if.sv
// Pixel stream bundle: one beat of PIX_PER_CLK packed pixels with row framing and valid/ready.
interface img_stream_src_if
  import img_pkg::*;
#(
  parameter int BEAT_W = beat_w(2, 3, 8)
) ();

  logic              pix_valid;
  logic              pix_ready;
  logic [BEAT_W-1:0] pix_data;
  logic              pix_sol;
  logic              pix_eol;

  modport master (output pix_valid, output pix_data, output pix_sol, output pix_eol,
                  input  pix_ready);
  modport slave  (input  pix_valid, input  pix_data, input  pix_sol, input  pix_eol,
                  output pix_ready);

endinterface

// File: rtl/img_stream_src_pix_skid_buf.sv
// Two-entry skid buffer absorbing the one-cycle RAM latency, so a read issued just
// before a stall still has a slot when its data returns.
module pix_skid_buf #(
  parameter int W = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready  = (cnt_q != 2'd2) || out_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent_q[rd_ptr_q];
  assign count     = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      ent_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the two entries are reset too, so out_data reads 0 after reset, not stale data.
      ent_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/img_stream_src.sv
// Image-frame source: fetches beats from a synchronous frame RAM and streams them with
// vsync/hsync framing. Define ROW_FLIP_EN to fetch rows bottom-up (BMP storage order).
module img_stream_src
  import img_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PIX_PER_CLK  = 2,
  parameter int CHAN_CNT     = 3,
  parameter int CHAN_W       = 8,
  parameter int VSYNC_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  localparam int BEAT_W = beat_w(PIX_PER_CLK, CHAN_CNT, CHAN_W),
  localparam int ADDR_W = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT, PIX_PER_CLK)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [BEAT_W-1:0]   mem_rd_data,
  img_stream_src_if.master    pix,
  output logic                vsync,
  output logic                hsync,
  output logic                busy,
  output logic                done
);

  localparam int BPR   = IMAGE_WIDTH / PIX_PER_CLK;
  localparam int BC_W  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int DLY_W = $clog2((VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY) + 1;

  if (IMAGE_WIDTH % PIX_PER_CLK != 0) begin : g_width_chk
    $error("IMAGE_WIDTH must be a multiple of PIX_PER_CLK");
  end

  logic [2:0]       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BC_W-1:0]  req_beat_q, req_beat_d;
  logic             req_done_q, req_done_d;
  logic             rd_pend_q, rd_pend_d;
  logic             pend_sol_q, pend_sol_d;
  logic             pend_eol_q, pend_eol_d;

  logic             rd_en;
  logic [2:0]       occ;
  logic             beat_pop, row_end;
  logic [ROW_W-1:0] phys_row;
  logic             skid_in_ready;
  logic [1:0]       skid_cnt;
  logic [BEAT_W+1:0] skid_out;

`ifdef ROW_FLIP_EN
  assign phys_row = ROW_W'(IMAGE_HEIGHT - 1) - row_q;
`else
  assign phys_row = row_q;
`endif

  assign beat_pop = pix.pix_valid && pix.pix_ready;
  assign row_end  = beat_pop && pix.pix_eol;
  // The beat leaving this cycle frees its slot, which keeps one beat per clock sustained.
  assign occ      = 3'(skid_cnt) + 3'(rd_pend_q) - 3'(beat_pop);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    row_d      = row_q;
    req_beat_d = req_beat_q;
    req_done_d = req_done_q;
    rd_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_VSYNC;
          dly_d   = '0;
        end
      end
      ST_VSYNC: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DLY_W'(VSYNC_DELAY - 1)) begin
          state_d = ST_HSYNC;
          dly_d   = '0;
        end
      end
      ST_HSYNC: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DLY_W'(HSYNC_DELAY - 1)) begin
          state_d = ST_ACTIVE;
          dly_d   = '0;
        end
      end
      ST_ACTIVE: begin
        rd_en = !req_done_q && (occ < 3'd2) && skid_in_ready;
        if (rd_en) begin
          if (req_beat_q == BC_W'(BPR - 1)) begin
            req_beat_d = '0;
            req_done_d = 1'b1;
          end else begin
            req_beat_d = req_beat_q + 1'b1;
          end
        end
        if (row_end) begin
          req_done_d = 1'b0;
          if (row_q == ROW_W'(IMAGE_HEIGHT - 1)) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_HSYNC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rd_pend_d  = rd_en;
    pend_sol_d = rd_en && (req_beat_q == '0);
    pend_eol_d = rd_en && (req_beat_q == BC_W'(BPR - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dly_q      <= '0;
      row_q      <= '0;
      req_beat_q <= '0;
      req_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      pend_sol_q <= 1'b0;
      pend_eol_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      row_q      <= row_d;
      req_beat_q <= req_beat_d;
      req_done_q <= req_done_d;
      rd_pend_q  <= rd_pend_d;
      pend_sol_q <= pend_sol_d;
      pend_eol_q <= pend_eol_d;
    end
  end

  pix_skid_buf #(
    .W (BEAT_W + 2)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_pend_q),
    .in_ready  (skid_in_ready),
    .in_data   ({pend_eol_q, pend_sol_q, mem_rd_data}),
    .out_valid (pix.pix_valid),
    .out_ready (pix.pix_ready),
    .out_data  (skid_out),
    .count     (skid_cnt)
  );

  assign pix.pix_data = skid_out[BEAT_W-1:0];
  assign pix.pix_sol  = skid_out[BEAT_W];
  assign pix.pix_eol  = skid_out[BEAT_W+1];

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? (ADDR_W'(phys_row) * ADDR_W'(BPR) + ADDR_W'(req_beat_q)) : '0;
  assign vsync     = (state_q == ST_VSYNC);
  assign hsync     = (state_q == ST_HSYNC);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule
